adder_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one Adder (ADD/SUB/CMP) among N_REQ requesters.

---
 rtl/adder_arbiter.sv | 154 +++++++++++++++
 tb/tb_adder_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sequencer sharing one ADD/SUB/CMP adder.
// Ports: clk, rst_n (async low); req_valid/ready/a/b/op in, one-hot
// rsp_valid with shared rsp_result/rsp_flag/rsp_err out; busy in EXEC/RESP.
module adder_arbiter #(
   parameter int WIDTH = 32,
   parameter int N_REQ = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   input  logic [N_REQ*2-1:0]     req_op,
   output logic [N_REQ-1:0]       rsp_valid,
   input  logic [N_REQ-1:0]       rsp_ready,
   output logic [WIDTH-1:0]       rsp_result,
   output logic [1:0]             rsp_flag,
   output logic                   rsp_err,
   output logic                   busy
);

   localparam int IDXW = $clog2(N_REQ);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

   logic [1:0]       state_q, state_d;
   logic [IDXW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [IDXW-1:0]  gnt_q, gnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [1:0]       flag_q, flag_d;
   logic             err_q, err_d;

   // Round-robin search starting at rr_ptr_q
   logic            found;
   logic [IDXW-1:0] pick;
   logic [IDXW:0]   idx;

   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = {1'b0, rr_ptr_q} + (IDXW+1)'(i);
         if (idx >= (IDXW+1)'(N_REQ))
            idx = idx - (IDXW+1)'(N_REQ);
         if (!found && req_valid[idx[IDXW-1:0]]) begin
            found = 1'b1;
            pick  = idx[IDXW-1:0];
         end
      end
   end

   // Shared adder: SUB and CMP both compute A + ~B + 1
   logic             sub;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic [1:0]       add_flag;

   always_comb begin
      sub   = (op_q != 2'b00);
      b_eff = sub ? ~b_q : b_q;
      sum   = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
      add_flag[0] = (sum[WIDTH-1:0] == '0);
      add_flag[1] = sum[WIDTH] & (sum[WIDTH-1:0] != '0);
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      gnt_d    = gnt_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      result_d = result_q;
      flag_d   = flag_q;
      err_d    = err_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               gnt_d   = pick;
               a_d     = req_a[pick*WIDTH +: WIDTH];
               b_d     = req_b[pick*WIDTH +: WIDTH];
               op_d    = req_op[pick*2 +: 2];
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (op_q == 2'b11) begin
               result_d = '0;
               flag_d   = 2'b00;
               err_d    = 1'b1;
            end else begin
               result_d = sum[WIDTH-1:0];
               flag_d   = add_flag;
               err_d    = 1'b0;
            end
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready[gnt_q]) begin
               // served requester drops to lowest priority
               if (gnt_q == IDXW'(N_REQ-1))
                  rr_ptr_d = '0;
               else
                  rr_ptr_d = gnt_q + 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         gnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= 2'b00;
         result_q <= '0;
         flag_q   <= 2'b00;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         gnt_q    <= gnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         result_q <= result_d;
         flag_q   <= flag_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      req_ready  = (state_q == IDLE && found) ? (ONE << pick) : '0;
      rsp_valid  = (state_q == RESP) ? (ONE << gnt_q) : '0;
      rsp_result = result_q;
      rsp_flag   = flag_q;
      rsp_err    = err_q;
      busy       = (state_q == EXEC) || (state_q == RESP);
   end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed checks of adder_arbiter (4 requesters, 32 bit).
// Covers arithmetic, round-robin order, response stall and mid-op reset.
module tb_adder_arbiter;

   localparam logic [1:0] ADD = 2'b00;
   localparam logic [1:0] SUB = 2'b01;
   localparam logic [1:0] CMP = 2'b10;
   localparam logic [1:0] RSV = 2'b11;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [127:0] req_a;
   logic [127:0] req_b;
   logic [7:0]   req_op;
   logic [3:0]   rsp_valid;
   logic [3:0]   rsp_ready;
   logic [31:0]  rsp_result;
   logic [1:0]   rsp_flag;
   logic         rsp_err;
   logic         busy;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   adder_arbiter #(.WIDTH(32), .N_REQ(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_flag(rsp_flag),
      .rsp_err(rsp_err), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int idx, input logic [31:0] a,
                          input logic [31:0] b, input logic [1:0] op);
      req_a[idx*32 +: 32] = a;
      req_b[idx*32 +: 32] = b;
      req_op[idx*2 +: 2]  = op;
   endtask

   // One isolated op from an idle DUT; called at a negedge.
   task automatic single(input int idx, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] op,
                         input logic [31:0] er, input logic [1:0] ef,
                         input logic ee, input string tag);
      logic [3:0] oh;
      oh = 4'b0001 << idx;
      set_req(idx, a, b, op);
      req_valid = oh;
      rsp_ready = 4'b0000;
      #1 chk({tag, "_req_ready"}, 64'(req_ready), 64'(oh));
      @(negedge clk);
      req_valid = 4'b0000;
      #1 chk({tag, "_exec_busy"}, 64'(busy), 64'd1);
      chk({tag, "_exec_rsp_valid"}, 64'(rsp_valid), 64'd0);
      @(negedge clk);
      #1 chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(oh));
      chk({tag, "_result"}, 64'(rsp_result), 64'(er));
      chk({tag, "_flag"}, 64'(rsp_flag), 64'(ef));
      chk({tag, "_err"}, 64'(rsp_err), 64'(ee));
      rsp_ready = oh;
      @(negedge clk);
      rsp_ready = 4'b0000;
      #1 chk({tag, "_rsp_drop"}, 64'(rsp_valid), 64'd0);
      chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
      @(negedge clk);
   endtask

   initial begin
      int n;
      int last;
      logic [3:0] oh;
      rst_n     = 1'b0;
      req_valid = 4'b0000;
      rsp_ready = 4'b0000;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;

      // reset state
      repeat (2) @(negedge clk);
      #1 chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_result", 64'(rsp_result), 64'd0);
      chk("rst_flag", 64'(rsp_flag), 64'd0);
      chk("rst_err", 64'(rsp_err), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // arithmetic; 5+3 has no carry-out so flag[1] stays low
      single(0, 32'd5, 32'd3, ADD, 32'd8, 2'b00, 1'b0, "add_5_3");
      single(0, 32'd3, 32'd5, SUB, 32'hFFFFFFFE, 2'b00, 1'b0, "sub_3_5");
      single(0, 32'd7, 32'd7, CMP, 32'd0, 2'b01, 1'b0, "cmp_7_7");
      single(0, 32'hFFFFFFFF, 32'd1, ADD, 32'd0, 2'b01, 1'b0, "add_wrap0");
      single(2, 32'd7, 32'd3, SUB, 32'd4, 2'b10, 1'b0, "sub_7_3");
      single(3, 32'hFFFFFFFF, 32'd2, ADD, 32'd1, 2'b10, 1'b0, "add_carry");

      // round robin with all requesters valid; pointer is back at 0
      for (int i = 0; i < 4; i++)
         set_req(i, 32'(i * 16 + 1), 32'd2, ADD);
      req_valid = 4'b1111;
      rsp_ready = 4'b1111;
      last = 0;
      for (int k = 0; k < 8; k++) begin
         n = 0;
         #1;
         while (req_ready == 4'b0000 && n < 20) begin
            @(negedge clk);
            #1 n++;
         end
         oh = 4'b0001 << (k % 4);
         chk("rr_grant", 64'(req_ready), 64'(oh));
         if (k > 0)
            chk("rr_gap_ge3", 64'((cyc - last) >= 3), 64'd1);
         last = cyc;
         n = 0;
         @(negedge clk);
         #1;
         while (rsp_valid == 4'b0000 && n < 20) begin
            @(negedge clk);
            #1 n++;
         end
         chk("rr_rsp_valid", 64'(rsp_valid), 64'(oh));
         chk("rr_result", 64'(rsp_result), 64'((k % 4) * 16 + 3));
         @(negedge clk);
      end
      req_valid = 4'b0000;
      rsp_ready = 4'b0000;
      @(negedge clk);

      // response stall with a pending request and wrong-owner ready
      set_req(1, 32'd100, 32'd23, ADD);
      req_valid = 4'b0010;
      #1 chk("stall_req_ready", 64'(req_ready), 64'b0010);
      @(negedge clk);
      set_req(0, 32'd40, 32'd2, ADD);
      req_valid = 4'b0001;
      @(negedge clk);
      for (int j = 0; j < 10; j++) begin
         rsp_ready = (j < 5) ? 4'b0000 : 4'b1101;
         #1 chk("stall_rsp_valid", 64'(rsp_valid), 64'b0010);
         chk("stall_result", 64'(rsp_result), 64'd123);
         chk("stall_req_ready0", 64'(req_ready), 64'd0);
         chk("stall_busy", 64'(busy), 64'd1);
         @(negedge clk);
      end
      rsp_ready = 4'b0010;
      @(negedge clk);
      rsp_ready = 4'b0000;
      #1 chk("stall_release", 64'(rsp_valid), 64'd0);
      chk("stall_next_grant", 64'(req_ready), 64'b0001);
      @(negedge clk);
      req_valid = 4'b0000;
      @(negedge clk);
      #1 chk("pend_rsp_valid", 64'(rsp_valid), 64'b0001);
      chk("pend_result", 64'(rsp_result), 64'd42);
      rsp_ready = 4'b0001;
      @(negedge clk);
      rsp_ready = 4'b0000;
      @(negedge clk);

      // reserved op, then reset during EXEC
      single(2, 32'd9, 32'd9, RSV, 32'd0, 2'b00, 1'b1, "rsv_op");
      single(1, 32'd2, 32'd2, ADD, 32'd4, 2'b00, 1'b0, "add_2_2");
      set_req(3, 32'd1, 32'd1, ADD);
      req_valid = 4'b1000;
      #1 chk("mid_req_ready", 64'(req_ready), 64'b1000);
      @(negedge clk);
      req_valid = 4'b0000;
      rst_n = 1'b0;
      #1 chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("mid_rst_result", 64'(rsp_result), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int j = 0; j < 4; j++) begin
         #1 chk("mid_no_rsp", 64'(rsp_valid), 64'd0);
         @(negedge clk);
      end
      req_valid = 4'b1111;
      #1 chk("mid_ptr_zero", 64'(req_ready), 64'b0001);
      req_valid = 4'b0000;
      @(negedge clk);
      #1 chk("end_busy", 64'(busy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
